// File: rtl/match_scan_unit_pkg.sv
// Shared constants and types for the byte-pattern scan engine.
package match_scan_unit_pkg;

   // Default geometry: 32-bit word, 8-bit pattern, 25 window positions.
   localparam int MATCH_DATA_W = 32;
   localparam int MATCH_PAT_W  = 8;
   localparam int MATCH_NPOS   = MATCH_DATA_W - MATCH_PAT_W + 1;

   // Reported when no window matches.
   localparam logic [31:0] MATCH_NONE = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      MS_IDLE = 2'd0,
      MS_SCAN = 2'd1,
      MS_DONE = 2'd2
   } ms_state_e;

   // Number of window positions for a given word/pattern width.
   function automatic int match_npos(input int data_w, input int pat_w);
      return data_w - pat_w + 1;
   endfunction

endpackage

// File: rtl/match_scan_if.sv
// EX-stage handshake between the pipeline and the scan engine.
interface match_scan_if #(
   parameter int DATA_W = 32,
   parameter int PAT_W  = 8
);
   logic              flush;
   logic              start;
   logic [PAT_W-1:0]  pattern;
   logic [DATA_W-1:0] data;
   logic              stallreq;
   logic              result_valid;
   logic [31:0]       result;

   // Pipeline side drives the operands and sees the stall/result.
   modport master (
      output flush, start, pattern, data,
      input  stallreq, result_valid, result
   );

   // Engine side.
   modport slave (
      input  flush, start, pattern, data,
      output stallreq, result_valid, result
   );
endinterface

// File: rtl/match_scan_unit_window_cmp.sv
// Compares LANES consecutive pattern windows starting at pos and returns
// the lowest matching offset. Windows past the last legal position are
// masked off so a partial final group never reports a bogus hit.
module match_window_cmp #(
   parameter int DATA_W = 32,
   parameter int PAT_W  = 8,
   parameter int LANES  = 1,
   parameter int POS_W  = 5
) (
   input  logic [DATA_W-1:0] data,
   input  logic [PAT_W-1:0]  pattern,
   input  logic [POS_W-1:0]  pos,
   output logic              hit,
   output logic [POS_W-1:0]  hit_pos
);
   localparam int NPOS = DATA_W - PAT_W + 1;

   logic [POS_W:0]    idx;
   logic [DATA_W-1:0] win;

   // Scan lanes from highest to lowest so the lowest hit overwrites the rest.
   always_comb begin
      hit     = 1'b0;
      hit_pos = pos;
      idx     = '0;
      win     = '0;
      for (int l = LANES - 1; l >= 0; l--) begin
         idx = {1'b0, pos} + (POS_W + 1)'(l);
         win = data >> idx;
         if ((idx < (POS_W + 1)'(NPOS)) && (win[PAT_W-1:0] == pattern)) begin
            hit     = 1'b1;
            hit_pos = idx[POS_W-1:0];
         end
      end
   end
endmodule

// File: rtl/match_scan_unit.sv
// Multi-cycle byte-pattern search for op_match. Holds the EX stage via
// stallreq while scanning LANES windows per cycle, then pulses result_valid
// for one cycle with the lowest matching bit offset (or MATCH_NONE).
module match_scan_unit
   import match_scan_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int PAT_W  = 8,
   parameter int LANES  = 1
) (
   input logic         clk,
   input logic         resetn,
   match_scan_if.slave bus
);
   localparam int NPOS  = match_npos(DATA_W, PAT_W);
   localparam int POS_W = (NPOS > 1) ? $clog2(NPOS) : 1;

   ms_state_e         state_q, state_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic [PAT_W-1:0]  pat_q, pat_d;
   logic [DATA_W-1:0] dat_q, dat_d;
   logic [31:0]       result_q, result_d;

   logic              win_hit;
   logic [POS_W-1:0]  win_pos;
   logic [POS_W:0]    pos_next;
   logic              stall_c, valid_c;

   match_window_cmp #(
      .DATA_W (DATA_W),
      .PAT_W  (PAT_W),
      .LANES  (LANES),
      .POS_W  (POS_W)
   ) u_cmp (
      .data    (dat_q),
      .pattern (pat_q),
      .pos     (pos_q),
      .hit     (win_hit),
      .hit_pos (win_pos)
   );

   assign pos_next = {1'b0, pos_q} + (POS_W + 1)'(LANES);

   // Next-state, operand latching and handshake outputs.
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      pat_d    = pat_q;
      dat_d    = dat_q;
      result_d = result_q;
      stall_c  = 1'b0;
      valid_c  = 1'b0;
      case (state_q)
         MS_IDLE: begin
            if (bus.start && !bus.flush) begin
               pat_d   = bus.pattern;
               dat_d   = bus.data;
               pos_d   = '0;
               state_d = MS_SCAN;
               stall_c = 1'b1;
            end
         end
         MS_SCAN: begin
            stall_c = 1'b1;
            if (bus.flush) begin
               state_d = MS_IDLE;
            end else if (win_hit) begin
               result_d = 32'(win_pos);
               state_d  = MS_DONE;
            end else if (pos_next >= (POS_W + 1)'(NPOS)) begin
               result_d = MATCH_NONE;
               state_d  = MS_DONE;
            end else begin
               pos_d = pos_next[POS_W-1:0];
            end
         end
         MS_DONE: begin
            // A flush landing on the result cycle kills the result too.
            valid_c = !bus.flush;
            state_d = MS_IDLE;
         end
         default: state_d = MS_IDLE;
      endcase
   end

   // Outputs are forced low while reset is held, even with start high.
   assign bus.stallreq     = stall_c & resetn;
   assign bus.result_valid = valid_c & resetn;
   assign bus.result       = result_q;

   // State, scan position, operand latches and result register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= MS_IDLE;
         pos_q    <= '0;
         pat_q    <= '0;
         dat_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         pat_q    <= pat_d;
         dat_q    <= dat_d;
         result_q <= result_d;
      end
   end
endmodule

// File: tb/tb_match_scan_unit.sv
// Directed bench: drives a LANES=1 and a LANES=4 engine with identical
// operands and checks latency, result, stall profile and pulse count.
module tb_match_scan_unit;
   logic clk;
   logic resetn;
   int   total;
   int   passed;

   match_scan_if #(.DATA_W(32), .PAT_W(8)) if1 ();
   match_scan_if #(.DATA_W(32), .PAT_W(8)) if4 ();

   match_scan_unit #(.DATA_W(32), .PAT_W(8), .LANES(1)) u1 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (if1.slave)
   );

   match_scan_unit #(.DATA_W(32), .PAT_W(8), .LANES(4)) u4 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (if4.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drive(input logic s, input logic f, input logic [7:0] p, input logic [31:0] d);
      if1.start = s; if1.flush = f; if1.pattern = p; if1.data = d;
      if4.start = s; if4.flush = f; if4.pattern = p; if4.data = d;
   endtask

   // Start at cycle 0, sample each cycle at the falling edge.
   task automatic search(input string tag, input logic [7:0] p, input logic [31:0] d,
                         input int e1_lat, input logic [31:0] e1_res,
                         input int e4_lat, input logic [31:0] e4_res);
      int lat1, lat4, n1, n4, se1, se4;
      logic [31:0] r1, r4;
      lat1 = -1; lat4 = -1; n1 = 0; n4 = 0; se1 = 0; se4 = 0; r1 = '0; r4 = '0;
      @(posedge clk); #1;
      drive(1'b1, 1'b0, p, d);
      for (int c = 0; c < 30; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 1) drive(1'b0, 1'b0, p, d);
         @(negedge clk);
         if (if1.result_valid) begin n1++; if (lat1 < 0) begin lat1 = c; r1 = if1.result; end end
         if (if4.result_valid) begin n4++; if (lat4 < 0) begin lat4 = c; r4 = if4.result; end end
         if (if1.stallreq !== (c < e1_lat)) se1++;
         if (if4.stallreq !== (c < e4_lat)) se4++;
      end
      chk({tag, " L1 latency"}, 32'(lat1), 32'(e1_lat));
      chk({tag, " L1 result"},  r1, e1_res);
      chk({tag, " L1 pulses"},  32'(n1), 32'd1);
      chk({tag, " L1 stall"},   32'(se1), 32'd0);
      chk({tag, " L4 latency"}, 32'(lat4), 32'(e4_lat));
      chk({tag, " L4 result"},  r4, e4_res);
      chk({tag, " L4 pulses"},  32'(n4), 32'd1);
      chk({tag, " L4 stall"},   32'(se4), 32'd0);
   endtask

   initial begin
      int n1, n4, se1, se4, lat1, lat4;
      logic [31:0] r1, r4;
      total = 0; passed = 0;

      // Reset: start held high must not leak through as a stall.
      resetn = 1'b0;
      drive(1'b1, 1'b0, 8'hAB, 32'h0000_00AB);
      #12;
      chk("rst L1 stall",  32'(if1.stallreq), 32'd0);
      chk("rst L1 valid",  32'(if1.result_valid), 32'd0);
      chk("rst L1 result", if1.result, 32'd0);
      chk("rst L4 stall",  32'(if4.stallreq), 32'd0);
      chk("rst L4 result", if4.result, 32'd0);
      drive(1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk); resetn = 1'b1;
      repeat (2) @(posedge clk);

      search("hit0",  8'hAB, 32'h0000_00AB,  2, 32'd0,        2, 32'd0);
      search("hit24", 8'hAB, 32'hAB00_0000, 26, 32'd24,       8, 32'd24);
      search("miss",  8'hFF, 32'h1234_5678, 26, 32'hFFFF_FFFF, 8, 32'hFFFF_FFFF);
      search("prio",  8'hFF, 32'h0000_FFF0,  6, 32'd4,        3, 32'd4);
      search("hit8",  8'hC3, 32'h0000_C300, 10, 32'd8,        4, 32'd8);
      search("miss0", 8'h00, 32'hFFFF_FFFF, 26, 32'hFFFF_FFFF, 8, 32'hFFFF_FFFF);

      // Flush at cycle 5 abandons the search; new start at cycle 7 hits at 0.
      n1 = 0; n4 = 0; se1 = 0; se4 = 0; lat1 = -1; lat4 = -1; r1 = '0; r4 = '0;
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 8'hAB, 32'hAB00_0000);
      for (int c = 0; c < 16; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         if (c == 1) drive(1'b0, 1'b0, 8'hAB, 32'hAB00_0000);
         if (c == 5) drive(1'b0, 1'b1, 8'hAB, 32'hAB00_0000);
         if (c == 6) drive(1'b0, 1'b0, 8'hAB, 32'hAB00_0000);
         if (c == 7) drive(1'b1, 1'b0, 8'hAB, 32'h0000_00AB);
         if (c == 8) drive(1'b0, 1'b0, 8'hAB, 32'h0000_00AB);
         @(negedge clk);
         if (if1.result_valid) begin n1++; if (lat1 < 0) begin lat1 = c; r1 = if1.result; end end
         if (if4.result_valid) begin n4++; if (lat4 < 0) begin lat4 = c; r4 = if4.result; end end
         if (if1.stallreq !== (c <= 5 || c == 7 || c == 8)) se1++;
         if (if4.stallreq !== (c <= 5 || c == 7 || c == 8)) se4++;
      end
      chk("flush L1 stall",   32'(se1), 32'd0);
      chk("flush L1 latency", 32'(lat1), 32'd9);
      chk("flush L1 result",  r1, 32'd0);
      chk("flush L1 pulses",  32'(n1), 32'd1);
      chk("flush L4 stall",   32'(se4), 32'd0);
      chk("flush L4 latency", 32'(lat4), 32'd9);
      chk("flush L4 pulses",  32'(n4), 32'd1);

      // Leave a nonzero result behind, then reset mid-scan.
      search("pre-rst", 8'hAB, 32'hAB00_0000, 26, 32'd24, 8, 32'd24);
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 8'hAB, 32'hAB00_0000);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 8'hAB, 32'hAB00_0000);
      repeat (2) @(posedge clk);
      #1;
      chk("scan L1 stall", 32'(if1.stallreq), 32'd1);
      resetn = 1'b0;
      #1;
      chk("arst L1 stall",  32'(if1.stallreq), 32'd0);
      chk("arst L1 valid",  32'(if1.result_valid), 32'd0);
      chk("arst L1 result", if1.result, 32'd0);
      chk("arst L4 stall",  32'(if4.stallreq), 32'd0);
      chk("arst L4 result", if4.result, 32'd0);
      @(negedge clk); resetn = 1'b1;
      search("post-rst", 8'hAB, 32'h0000_00AB, 2, 32'd0, 2, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
